sim_uart_tx: RTL

- Bench-side UART transmitter model that drives the DUT UART receive pin (i_uart1_rd).
- Counterpart of the existing UART receive monitor: the bench uses it to inject console bytes into the SoC.
- Bytes are queued in a small FIFO and serialized as 8N1 frames, LSB first, idle-high line.
- Baud rate is set by a runtime clock divider, so the same block serves speed-up and real-rate simulations.

---
 rtl/sim_uart_tx.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/sim_uart_tx.sv
// sim_uart_tx: bench-side UART transmitter that drives the SoC receive pin.
// Bytes are queued in a small FIFO and sent as 8N1 frames (LSB first, idle high)
// at a baud rate set by a runtime clock divider (i_scaler clocks per bit).
// Optional feature macro: SIM_UART_TX_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit (11 bit times per frame).
//
// Handshake: i_we is a one-cycle write strobe with no ready return; a write is
// accepted when the FIFO has room or a pop happens in the same cycle, otherwise
// it is silently dropped. Callers watch o_full before writing.
module sim_uart_tx #(
    parameter int p_fifo_log2 = 4,
    parameter int p_scaler_w  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [p_scaler_w-1:0] i_scaler,
    input  logic                  i_we,
    input  logic [7:0]            i_wdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_td
);

    localparam int lp_depth = 2 ** p_fifo_log2;
    localparam logic [p_fifo_log2:0]   lp_depth_c   = {1'b1, {p_fifo_log2{1'b0}}};
    localparam logic [p_fifo_log2:0]   lp_cnt_one   = (p_fifo_log2+1)'(1);
    localparam logic [p_fifo_log2-1:0] lp_ptr_one   = p_fifo_log2'(1);
    localparam logic [p_scaler_w-1:0]  lp_div_one   = p_scaler_w'(1);
    localparam logic [p_scaler_w-1:0]  lp_div_two   = p_scaler_w'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef SIM_UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]             r_mem [lp_depth];
    logic [p_fifo_log2-1:0] r_wr_ptr;
    logic [p_fifo_log2-1:0] r_rd_ptr;
    logic [p_fifo_log2:0]   r_count;
    logic                   r_full;
    logic                   r_empty;

    // Serializer state
    state_t                 r_state;
    logic [7:0]             r_shift;
    logic [2:0]             r_bit_idx;
    logic [p_scaler_w-1:0]  r_div;
    logic [p_scaler_w-1:0]  r_eff;
    logic                   r_td;
    logic                   r_busy;
    logic                   r_done;
`ifdef SIM_UART_TX_PARITY_EN
    logic                   r_par;
`endif

    logic                   w_pop;
    logic                   w_push;
    logic [p_fifo_log2:0]   w_count_nxt;
    logic [7:0]             w_head;
    logic [p_scaler_w-1:0]  w_eff_scaler;
    logic                   w_bit_end;
    logic                   w_stop_last_next;

    // The serializer pops the head whenever it is idle and data is waiting.
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
    // A write into a full FIFO still fits if the head leaves in the same cycle.
    assign w_push = i_we && ((r_count != lp_depth_c) || w_pop);
    assign w_head = r_mem[r_rd_ptr];

    // Divide-by-1 cannot produce a valid bit, so the divider is clamped to 2.
    assign w_eff_scaler     = (i_scaler < lp_div_two) ? lp_div_two : i_scaler;
    assign w_bit_end        = (r_div == (r_eff - lp_div_one));
    // True on the clock that moves the stop bit into its final cycle.
    assign w_stop_last_next = (r_div == (r_eff - lp_div_two));

    // Next FIFO occupancy from simultaneous push/pop.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + lp_cnt_one;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - lp_cnt_one;
        end
    end

    // FIFO pointers, count and registered full/empty flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + lp_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + lp_ptr_one;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == lp_depth_c);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // FIFO storage; contents need no reset since the pointers are cleared.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Frame serializer: start bit, 8 data bits LSB first, optional parity, stop bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_div     <= '0;
            r_eff     <= lp_div_two;
            r_td      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SIM_UART_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_td  <= 1'b1;
                    r_div <= '0;
                    if (w_pop) begin
                        r_shift   <= w_head;
                        r_eff     <= w_eff_scaler;
                        r_bit_idx <= '0;
                        r_state   <= S_START;
                        r_td      <= 1'b0;
                        r_busy    <= 1'b1;
`ifdef SIM_UART_TX_PARITY_EN
                        r_par     <= ^w_head;
`endif
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_div   <= '0;
                        r_state <= S_DATA;
                        r_td    <= r_shift[0];
                    end else begin
                        r_div <= r_div + lp_div_one;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_div <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef SIM_UART_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_td    <= r_par;
`else
                            r_state <= S_STOP;
                            r_td    <= 1'b1;
`endif
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_td      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_div <= r_div + lp_div_one;
                    end
                end
`ifdef SIM_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_div   <= '0;
                        r_state <= S_STOP;
                        r_td    <= 1'b1;
                    end else begin
                        r_div <= r_div + lp_div_one;
                    end
                end
`endif
                S_STOP: begin
                    r_td <= 1'b1;
                    if (w_bit_end) begin
                        r_div   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_div  <= r_div + lp_div_one;
                        r_done <= w_stop_last_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_td    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_div   <= '0;
                end
            endcase
        end
    end

    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_td    = r_td;

endmodule
